// File: rtl/tbman_apb_arb.sv
// tbman_apb_arb: two-master APB arbiter replaying each granted transfer to the tbman slave.
// Define TBMAN_ARB_RR_EN for round-robin contention; default is fixed priority to master 0.
module tbman_apb_arb #(
    parameter int W_ADDR = 16,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apbs0_psel,
    input  logic              apbs0_penable,
    input  logic              apbs0_pwrite,
    input  logic [W_ADDR-1:0] apbs0_paddr,
    input  logic [W_DATA-1:0] apbs0_pwdata,
    output logic [W_DATA-1:0] apbs0_prdata,
    output logic              apbs0_pready,
    output logic              apbs0_pslverr,
    input  logic              apbs1_psel,
    input  logic              apbs1_penable,
    input  logic              apbs1_pwrite,
    input  logic [W_ADDR-1:0] apbs1_paddr,
    input  logic [W_DATA-1:0] apbs1_pwdata,
    output logic [W_DATA-1:0] apbs1_prdata,
    output logic              apbs1_pready,
    output logic              apbs1_pslverr,
    output logic              apbm_psel,
    output logic              apbm_penable,
    output logic              apbm_pwrite,
    output logic [W_ADDR-1:0] apbm_paddr,
    output logic [W_DATA-1:0] apbm_pwdata,
    input  logic [W_DATA-1:0] apbm_prdata,
    input  logic              apbm_pready,
    input  logic              apbm_pslverr,
    output logic [1:0]        gnt
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state;
    logic gnt_r;
    logic pri;
    logic active;
    logic access;
    logic unused_penable;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (apbs0_psel || apbs1_psel) begin
                    gnt_r <= apbs1_psel & (!apbs0_psel | pri);
                    state <= SETUP;
                end
                SETUP: state <= ACCESS;
                ACCESS: if (apbm_pready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef TBMAN_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            pri <= 1'b0;
        else if (state == ACCESS && apbm_pready)
            pri <= !gnt_r;
    end
`else
    assign pri = 1'b0;
`endif
    // Upstream penable carries no information the arbiter needs; grant is decided on psel alone.
    assign unused_penable = apbs0_penable ^ apbs1_penable;
    assign active = state != IDLE;
    assign access = state == ACCESS;
    assign apbm_psel    = active;
    assign apbm_penable = access;
    assign apbm_pwrite  = active & (gnt_r ? apbs1_pwrite : apbs0_pwrite);
    assign apbm_paddr   = active ? (gnt_r ? apbs1_paddr : apbs0_paddr) : '0;
    assign apbm_pwdata  = active ? (gnt_r ? apbs1_pwdata : apbs0_pwdata) : '0;
    assign gnt          = active ? (gnt_r ? 2'b10 : 2'b01) : 2'b00;
    assign apbs0_pready  = access & !gnt_r & apbm_pready;
    assign apbs1_pready  = access & gnt_r & apbm_pready;
    assign apbs0_pslverr = apbs0_pready & apbm_pslverr;
    assign apbs1_pslverr = apbs1_pready & apbm_pslverr;
    assign apbs0_prdata  = (access && !gnt_r) ? apbm_prdata : '0;
    assign apbs1_prdata  = (access && gnt_r) ? apbm_prdata : '0;
endmodule

// File: tb/tb_tbman_apb_arb.sv
// tb_tbman_apb_arb: directed bench for tbman_apb_arb with a simple wait-state slave model.
module tb_tbman_apb_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = '0, penable = '0, pwrite = '0;
    logic [15:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic [1:0]  pready, pslverr;
    logic        apbm_psel, apbm_penable, apbm_pwrite;
    logic [15:0] apbm_paddr;
    logic [31:0] apbm_pwdata;
    logic        apbm_pready;
    logic [1:0]  gnt;
    int          slv_wait = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          wcnt = 0;
    int          checks = 0, errors = 0;
    logic        pr0_seen = 1'b0, err0_bad = 1'b0, err1_seen = 1'b0;
    logic [1:0]  gq [$];
    logic [1:0]  exp_g [8];

    always #5 clk = ~clk;

    tbman_apb_arb dut (
        .clk(clk), .rst_n(rst_n),
        .apbs0_psel(psel[0]), .apbs0_penable(penable[0]), .apbs0_pwrite(pwrite[0]),
        .apbs0_paddr(paddr[0]), .apbs0_pwdata(pwdata[0]), .apbs0_prdata(prdata[0]),
        .apbs0_pready(pready[0]), .apbs0_pslverr(pslverr[0]),
        .apbs1_psel(psel[1]), .apbs1_penable(penable[1]), .apbs1_pwrite(pwrite[1]),
        .apbs1_paddr(paddr[1]), .apbs1_pwdata(pwdata[1]), .apbs1_prdata(prdata[1]),
        .apbs1_pready(pready[1]), .apbs1_pslverr(pslverr[1]),
        .apbm_psel(apbm_psel), .apbm_penable(apbm_penable), .apbm_pwrite(apbm_pwrite),
        .apbm_paddr(apbm_paddr), .apbm_pwdata(apbm_pwdata), .apbm_prdata(slv_rdata),
        .apbm_pready(apbm_pready), .apbm_pslverr(slv_err), .gnt(gnt)
    );

    // Slave holds pready low for slv_wait access cycles.
    assign apbm_pready = apbm_penable && (wcnt == slv_wait);
    always @(posedge clk) wcnt <= (apbm_penable && !apbm_pready) ? wcnt + 1 : 0;

    always @(negedge clk) begin
        if (pready[0]) pr0_seen = 1'b1;
        if (pslverr[0] && !pready[0]) err0_bad = 1'b1;
        if (pslverr[1]) err1_seen = 1'b1;
        if (apbm_psel && !apbm_penable) gq.push_back(gnt);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after completion with psel released.
    task automatic xfer(input int m, input logic wr, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int n);
        n = 0;
        psel[m] = 1'b1; penable[m] = 1'b0; pwrite[m] = wr; paddr[m] = a; pwdata[m] = d;
        @(negedge clk);
        penable[m] = 1'b1;
        while (!pready[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_seen", {31'd0, pready[m]}, 1);
        rd = prdata[m];
        err = pslverr[m];
        @(negedge clk);
        psel[m] = 1'b0; penable[m] = 1'b0;
    endtask

    task automatic run4(input int m);
        logic [31:0] rd;
        logic        err;
        int          n;
        for (int i = 0; i < 4; i++) xfer(m, 1'b1, 16'(m * 16 + i * 4), 32'(m * 256 + i), rd, err, n);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          n;
        paddr[0] = '0; paddr[1] = '0; pwdata[0] = '0; pwdata[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_psel", {31'd0, apbm_psel}, 0);
        chk("rst_gnt", {30'd0, gnt}, 0);
        chk("rst_paddr", {16'd0, apbm_paddr}, 0);
        chk("rst_pready", {30'd0, pready}, 0);
        rst_n = 1'b1;
        // single write from master 0
        psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 16'h0000; pwdata[0] = 32'h41;
        chk("wr_idle_psel", {31'd0, apbm_psel}, 0);
        @(negedge clk);
        chk("wr_setup_psel", {31'd0, apbm_psel}, 1);
        chk("wr_setup_pen", {31'd0, apbm_penable}, 0);
        chk("wr_setup_gnt", {30'd0, gnt}, 2'b01);
        chk("wr_setup_rdy", {30'd0, pready}, 0);
        penable[0] = 1'b1;
        @(negedge clk);
        chk("wr_acc_pen", {31'd0, apbm_penable}, 1);
        chk("wr_acc_pwrite", {31'd0, apbm_pwrite}, 1);
        chk("wr_acc_pwdata", apbm_pwdata, 32'h41);
        chk("wr_acc_paddr", {16'd0, apbm_paddr}, 0);
        chk("wr_acc_rdy", {30'd0, pready}, 2'b01);
        chk("wr_acc_gnt", {30'd0, gnt}, 2'b01);
        @(negedge clk);
        chk("wr_done_rdy", {30'd0, pready}, 0);
        chk("wr_done_gnt", {30'd0, gnt}, 0);
        chk("wr_done_psel", {31'd0, apbm_psel}, 0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        // read from master 1 with 3 downstream wait states
        slv_wait = 3; slv_rdata = 32'h3; pr0_seen = 1'b0;
        xfer(1, 1'b0, 16'h000C, 32'h0, rd, err, n);
        chk("rd_data", rd, 32'h3);
        chk("rd_waits", n, 4);
        chk("rd_err", {31'd0, err}, 0);
        chk("rd_m0_quiet", {31'd0, pr0_seen}, 0);
        // error passthrough for master 0
        slv_wait = 0; slv_err = 1'b1; err0_bad = 1'b0; err1_seen = 1'b0;
        xfer(0, 1'b1, 16'h0004, 32'h55, rd, err, n);
        chk("err_m0", {31'd0, err}, 1);
        chk("err_m0_only_rdy", {31'd0, err0_bad}, 0);
        chk("err_m1_quiet", {31'd0, err1_seen}, 0);
        slv_err = 1'b0;
        // reset while downstream stalls in ACCESS
        slv_wait = 20;
        psel[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 16'h0008;
        @(negedge clk);
        penable[0] = 1'b1;
        @(negedge clk);
        chk("rst_acc_pen", {31'd0, apbm_penable}, 1);
        chk("rst_acc_gnt", {30'd0, gnt}, 2'b01);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_abort_psel", {31'd0, apbm_psel}, 0);
        chk("rst_abort_gnt", {30'd0, gnt}, 0);
        chk("rst_abort_rdy", {30'd0, pready}, 0);
        rst_n = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0; slv_wait = 0;
        @(negedge clk);
        // contention: both masters issue 4 back-to-back writes
`ifdef TBMAN_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        gq.delete();
        fork
            run4(0);
            run4(1);
        join
        @(negedge clk);
        chk("cont_setups", gq.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("cont_gnt%0d", i), {30'd0, (i < gq.size()) ? gq[i] : 2'b11}, {30'd0, exp_g[i]});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
